// File: rtl/cas_buffer_pkg.sv
// cas_buffer_pkg: shared types and defaults for the cassette buffer arbiter.
// Contents: arb_state_t FSM encoding, AW_DEF (byte address width), MAX_WR_BURST_DEF.
package cas_buffer_pkg;
  localparam int AW_DEF = 27;
  localparam int MAX_WR_BURST_DEF = 16;
  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, WAIT_WR, WAIT_RD} arb_state_t;
endpackage

// File: rtl/cas_read_cache.sv
// cas_read_cache: one-byte playback read cache with write coherence and flush.
// Ports: clk/reset_n; flush invalidates; lookup_addr -> hit; upd_* is an issued
// write (updates data on address match); fill_* loads a completed read; data is the cached byte.
module cas_read_cache import cas_buffer_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_addr,
  input  logic [7:0]    upd_data,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_addr,
  input  logic [7:0]    fill_data,
  output logic [7:0]    data
);
  logic          valid;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;
  logic          upd_match;
  assign hit = valid && addr_q == lookup_addr;
  assign upd_match = upd_en && addr_q == upd_addr;
  // forward a same-cycle write so a hit never returns the stale byte
  assign data = upd_match ? upd_data : data_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (fill_en) begin
        valid  <= 1'b1;
        addr_q <= fill_addr;
        data_q <= fill_data;
      end else if (upd_match) data_q <= upd_data;
      if (flush) valid <= 1'b0;
    end
  end
endmodule

// File: rtl/cas_buffer_arbiter.sv
// cas_buffer_arbiter: shares the single-port cassette DDRAM buffer between the CAS download writer and the playback reader.
// Ports: clk/reset_n; flush; writer wr_strobe/wr_addr/wr_data/wr_wait;
// reader rd_req/rd_addr/rd_valid/rd_data; memory mem_addr/mem_din/mem_we/mem_rd/mem_dout/mem_ready.
module cas_buffer_arbiter import cas_buffer_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int MAX_WR_BURST = MAX_WR_BURST_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          wr_strobe,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_wait,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready
);
  localparam int CW = $clog2(MAX_WR_BURST + 1);
  arb_state_t    state, state_nx;
  logic          wr_full;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic          rd_pend;
  logic [AW-1:0] rd_addr_q;
  logic          rd_drop;
  logic [CW-1:0] burst_cnt;
  logic          rd_pend_eff, force_rd, grant_wr, grant_rd, rd_done, fill_en;
  logic          hit_req, miss_req, cache_hit;
  logic [7:0]    cache_data;
  assign wr_wait = wr_full;
  // flush kills the pending read in the same cycle, so it can no longer be granted
  assign rd_pend_eff = rd_pend && !flush;
  assign force_rd = rd_pend_eff && burst_cnt >= CW'(MAX_WR_BURST);
  assign grant_wr = state == IDLE && mem_ready && wr_full && !force_rd;
  assign grant_rd = state == IDLE && mem_ready && rd_pend_eff && !grant_wr;
  assign rd_done = state == WAIT_RD && mem_ready;
  // a read flushed while outstanding completes silently
  assign fill_en = rd_done && !rd_drop && !flush;
  assign hit_req = rd_req && !flush && !rd_pend && cache_hit;
  assign miss_req = rd_req && !flush && !rd_pend && !cache_hit;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = grant_wr ? WR_ISSUE : grant_rd ? RD_ISSUE : IDLE;
      WR_ISSUE: state_nx = WAIT_WR;
      RD_ISSUE: state_nx = WAIT_RD;
      WAIT_WR:  state_nx = mem_ready ? IDLE : WAIT_WR;
      WAIT_RD:  state_nx = mem_ready ? IDLE : WAIT_RD;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_full   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      rd_drop   <= 1'b0;
      burst_cnt <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
    end else begin
      state  <= state_nx;
      mem_we <= grant_wr;
      mem_rd <= grant_rd;
      if (grant_wr) begin
        mem_addr <= wr_addr_q;
        mem_din  <= wr_data_q;
      end else if (grant_rd) mem_addr <= rd_addr_q;
      if (state == WR_ISSUE) wr_full <= 1'b0;
      if (wr_strobe && !wr_full) begin
        wr_full   <= 1'b1;
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
      rd_valid <= hit_req || fill_en;
      if (hit_req) rd_data <= cache_data;
      else if (fill_en) rd_data <= mem_dout;
      // a dropped completion must not clear a request captured after the flush
      if (rd_done && !rd_drop) rd_pend <= 1'b0;
      if (miss_req) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= rd_addr;
      end
      if (flush) rd_pend <= 1'b0;
      if (flush && (state == RD_ISSUE || (state == WAIT_RD && !mem_ready))) rd_drop <= 1'b1;
      else if (rd_done) rd_drop <= 1'b0;
      if (!rd_pend_eff || grant_rd) burst_cnt <= '0;
      else if (grant_wr) burst_cnt <= burst_cnt + 1'b1;
    end
  end
  cas_read_cache #(.AW(AW)) u_cache (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .lookup_addr(rd_addr),
    .hit        (cache_hit),
    .upd_en     (state == WR_ISSUE),
    .upd_addr   (wr_addr_q),
    .upd_data   (wr_data_q),
    .fill_en    (fill_en),
    .fill_addr  (rd_addr_q),
    .fill_data  (mem_dout),
    .data       (cache_data)
  );
  a_wr_overrun: assert property (@(posedge clk) disable iff (!reset_n) !(wr_strobe && wr_full));
  a_rd_overrun: assert property (@(posedge clk) disable iff (!reset_n) !(rd_req && rd_pend && !flush));
endmodule
